// File: rtl/panda_risc_v_imem_icb_slave_pkg.sv
// Shared ICB field widths, response entry layout and error codes for the
// instruction-memory ICB slave.
package panda_risc_v_imem_icb_slave_pkg;

    localparam int ICB_ADDR_W     = 32;
    localparam int ICB_DATA_W     = 32;
    localparam int ICB_MASK_W     = 4;
    localparam int RSP_FIFO_DEPTH = 3;

    localparam logic ERR_NONE   = 1'b0;
    localparam logic ERR_ACCESS = 1'b1;

    typedef struct packed {
        logic [ICB_DATA_W-1:0] rdata;
        logic                  err;
    } rsp_entry_t;

endpackage

// File: rtl/panda_risc_v_imem_icb_slave_if.sv
// ICB command/response channel bundle between an instruction bus master and
// the instruction-memory slave.
interface panda_risc_v_imem_icb_slave_if;
    import panda_risc_v_imem_icb_slave_pkg::*;

    logic [ICB_ADDR_W-1:0] cmd_addr;
    logic                  cmd_read;
    logic [ICB_DATA_W-1:0] cmd_wdata;
    logic [ICB_MASK_W-1:0] cmd_wmask;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ICB_DATA_W-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_valid;
    logic                  rsp_ready;

    modport master (
        output cmd_addr, cmd_read, cmd_wdata, cmd_wmask, cmd_valid, rsp_ready,
        input  cmd_ready, rsp_rdata, rsp_err, rsp_valid
    );

    modport slave (
        input  cmd_addr, cmd_read, cmd_wdata, cmd_wmask, cmd_valid, rsp_ready,
        output cmd_ready, rsp_rdata, rsp_err, rsp_valid
    );

endinterface

// File: rtl/panda_risc_v_rsp_fifo.sv
// 3-entry in-order response FIFO; head presented with valid/ready, occupancy
// exported so the slave can run its credit check.
module panda_risc_v_rsp_fifo
    import panda_risc_v_imem_icb_slave_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  rsp_entry_t push_data,
    output logic       out_valid,
    input  logic       out_ready,
    output rsp_entry_t out_data,
    output logic [1:0] cnt
);

    localparam logic [1:0] LAST = 2'(RSP_FIFO_DEPTH - 1);
    localparam logic [1:0] FULL = 2'(RSP_FIFO_DEPTH);

    rsp_entry_t mem [RSP_FIFO_DEPTH];
    logic [1:0] wptr;
    logic [1:0] rptr;
    logic       do_push;
    logic       do_pop;

    function automatic logic [1:0] ptr_next(input logic [1:0] p);
        return (p == LAST) ? 2'd0 : p + 2'd1;
    endfunction

    assign out_valid = (cnt != 2'd0);
    assign do_pop    = out_valid & out_ready;
    assign do_push   = push & ((cnt != FULL) | do_pop);
    // Empty FIFO presents an all-zero payload so reset leaves rdata/err at 0.
    assign out_data  = out_valid ? mem[rptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem[wptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= 2'd0;
            rptr <= 2'd0;
            cnt  <= 2'd0;
        end else begin
            if (do_push) wptr <= ptr_next(wptr);
            if (do_pop)  rptr <= ptr_next(rptr);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/panda_risc_v_imem_icb_slave.sv
// ICB slave in front of the ITCM SRAM: decodes and launches accesses on the
// command handshake, stages one pending access, and queues in-order responses.
module panda_risc_v_imem_icb_slave
    import panda_risc_v_imem_icb_slave_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH       = 4096,
    parameter logic [31:0] BASE_ADDR        = 32'h0000_0000,
    parameter int unsigned simulation_delay = 1,
    localparam int unsigned AW              = $clog2(IMEM_DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    panda_risc_v_imem_icb_slave_if.slave s_icb,
    output logic                         sram_en,
    output logic [ICB_MASK_W-1:0]        sram_wen,
    output logic [AW-1:0]                sram_addr,
    output logic [ICB_DATA_W-1:0]        sram_din,
    input  logic [ICB_DATA_W-1:0]        sram_dout
);

    localparam logic [32:0] SPAN = 33'(IMEM_DEPTH) << 2;

    logic [32:0] offset;
    logic        cmd_err;
    logic        cmd_hs;
    logic        pend;
    logic        pend_err;
    logic        pend_rd;
    logic [1:0]  fifo_cnt;
    rsp_entry_t  push_data;
    rsp_entry_t  head;
    logic        head_valid;

    // 33-bit offset: bit 32 flags addresses below BASE_ADDR, no wrap at the top.
    assign offset  = {1'b0, s_icb.cmd_addr} - {1'b0, BASE_ADDR};
    assign cmd_err = (s_icb.cmd_addr[1:0] != 2'b00) | offset[32] | (offset >= SPAN);

    // Credits count both the pending access and queued responses, so the FIFO
    // cannot overflow and rsp_ready never reaches cmd_ready combinationally.
    assign s_icb.cmd_ready = !rst & (({1'b0, fifo_cnt} + {2'b00, pend}) < 3'(RSP_FIFO_DEPTH));
    assign cmd_hs          = s_icb.cmd_valid & s_icb.cmd_ready;

    assign sram_en   = cmd_hs & !cmd_err;
    assign sram_wen  = (sram_en & !s_icb.cmd_read) ? s_icb.cmd_wmask : '0;
    assign sram_addr = offset[AW+1:2];
    assign sram_din  = s_icb.cmd_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend     <= 1'b0;
            pend_err <= 1'b0;
            pend_rd  <= 1'b0;
        end else begin
            pend     <= cmd_hs;
            pend_err <= cmd_err;
            pend_rd  <= s_icb.cmd_read;
        end
    end

    always_comb begin
        push_data       = '0;
        push_data.rdata = (pend_rd & !pend_err) ? sram_dout : '0;
        push_data.err   = pend_err ? ERR_ACCESS : ERR_NONE;
    end

    panda_risc_v_rsp_fifo u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (pend),
        .push_data (push_data),
        .out_valid (head_valid),
        .out_ready (s_icb.rsp_ready),
        .out_data  (head),
        .cnt       (fifo_cnt)
    );

    assign s_icb.rsp_valid = head_valid;
    assign s_icb.rsp_rdata = head.rdata;
    assign s_icb.rsp_err   = head.err;

endmodule
